// File: rtl/nn_pkg.sv
// Shared constants and types for the quantized MNIST classifier and its
// image stream loader.
package nn_pkg;

  localparam int NN_DATA_W   = 16;
  localparam int NN_N_PIXELS = 784;

  typedef logic signed [NN_DATA_W-1:0] nn_data_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } img_ld_state_e;

endpackage

// File: rtl/pixel_index_counter.sv
// Wrapping pixel index counter: clear, load-to-1 (frame resync) and increment,
// with a terminal-count flag at N-1.
module pixel_index_counter #(
  parameter int N     = 784,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  assign tc = (count == CNT_W'(N - 1));

  // Priority clear > load-to-1 > increment; increment at terminal count wraps.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load1) begin
      count <= CNT_W'(1);
    end else if (inc) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of block evaluation order.
      count <= tc ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/image_stream_loader.sv
// Serial pixel stream to parallel image buffer loader for the MNIST network.
// Optional framing by start-of-frame marker when IMG_LOADER_SOF_EN is defined.
module image_stream_loader
  import nn_pkg::*;
#(
  parameter int N_PIXELS = NN_N_PIXELS,
  parameter int DATA_W   = NN_DATA_W,
  parameter int CNT_W    = $clog2(N_PIXELS + 1)
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic signed [DATA_W-1:0] pixel_data,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
`ifdef IMG_LOADER_SOF_EN
  input  logic                     pixel_sof,
  output logic                     sync_err,
`endif
  input  logic                     nn_done,
  output logic signed [DATA_W-1:0] image_out [0:N_PIXELS-1],
  output logic                     start,
  output logic                     busy,
  output logic [CNT_W-1:0]         pixel_count
);

  img_ld_state_e    state;
  logic             accept;
  logic             resync;
  logic             drop;
  logic             wr_en;
  logic [CNT_W-1:0] wr_idx;
  logic             tc;
  logic             last_beat;

  assign pixel_ready = (state == LOAD);
  assign accept      = pixel_valid && pixel_ready;

`ifdef IMG_LOADER_SOF_EN
  // A marker mid-frame restarts the frame at index 0; an unmarked first beat
  // cannot be placed and is discarded.
  assign resync = accept &&  pixel_sof && (pixel_count != '0);
  assign drop   = accept && !pixel_sof && (pixel_count == '0);
`else
  assign resync = 1'b0;
  assign drop   = 1'b0;
`endif

  assign wr_en     = accept && !drop;
  assign wr_idx    = resync ? '0 : pixel_count;
  assign last_beat = wr_en && !resync && tc;

  pixel_index_counter #(
    .N     (N_PIXELS),
    .CNT_W (CNT_W)
  ) u_index (
    .clk   (clk),
    .rstN  (rstN),
    .clr   (1'b0),
    .load1 (resync),
    .inc   (wr_en && !resync),
    .count (pixel_count),
    .tc    (tc)
  );

  // NOTE: the image buffer is a flop array, not RAM, because the network reads
  // all entries in parallel and reset must clear every entry.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < N_PIXELS; k++) image_out[k] <= '0;
    end else if (wr_en) begin
      image_out[wr_idx] <= pixel_data;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= LOAD;
      start <= 1'b0;
      busy  <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        LOAD: if (last_beat) begin
          state <= FIRE;
          start <= 1'b1;
        end
        FIRE: begin
          state <= WAIT;
          busy  <= 1'b1;
        end
        WAIT: if (nn_done) begin
          state <= LOAD;
          busy  <= 1'b0;
        end
        default: begin
          state <= LOAD;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IMG_LOADER_SOF_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) sync_err <= 1'b0;
    else       sync_err <= resync || drop;
  end
`endif

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader: full frames, WAIT back-pressure,
// gapped extreme values, mid-frame reset, ignored nn_done and optional SOF framing.
module tb_image_stream_loader;
  import nn_pkg::*;

  localparam int NP = NN_N_PIXELS;
  localparam int CW = $clog2(NP + 1);

  logic                 clk;
  logic                 rstN;
  nn_data_t             pixel_data;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic                 nn_done;
  nn_data_t             image_out [0:NP-1];
  logic                 start;
  logic                 busy;
  logic [CW-1:0]        pixel_count;
`ifdef IMG_LOADER_SOF_EN
  logic                 pixel_sof;
  logic                 sync_err;
`endif

  image_stream_loader dut (
    .clk         (clk),
    .rstN        (rstN),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
`ifdef IMG_LOADER_SOF_EN
    .pixel_sof   (pixel_sof),
    .sync_err    (sync_err),
`endif
    .nn_done     (nn_done),
    .image_out   (image_out),
    .start       (start),
    .busy        (busy),
    .pixel_count (pixel_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  typedef struct {
    logic     valid;
    logic     sof;
    nn_data_t data;
    int       exp_count;
  } vec_t;

  vec_t     vecs [10];
  nn_data_t exp_img [6];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample #1 after the rising edge.
  task automatic send_beat(input logic v, input nn_data_t d, input logic sof);
    pixel_valid = v;
    pixel_data  = d;
`ifdef IMG_LOADER_SOF_EN
    pixel_sof   = sof;
`else
    if (sof) pixel_data = d;
`endif
    @(posedge clk);
    #1;
    if (start) n_start++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int early;
    int bad;
    int rdy_seen;
    int s0;

    rstN        = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    nn_done     = 1'b0;
`ifdef IMG_LOADER_SOF_EN
    pixel_sof   = 1'b0;
`endif

    vecs[0] = '{1'b1, 1'b1, 16'hFFFF, 1};
    vecs[1] = '{1'b0, 1'b0, 16'h0005, 1};
    vecs[2] = '{1'b1, 1'b0, 16'h7FFF, 2};
    vecs[3] = '{1'b0, 1'b0, 16'hFFF9, 2};
    vecs[4] = '{1'b1, 1'b0, 16'h8000, 3};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 4};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 4};
    vecs[7] = '{1'b1, 1'b0, 16'h7FFF, 5};
    vecs[8] = '{1'b1, 1'b0, 16'h8000, 6};
    vecs[9] = '{1'b0, 1'b0, 16'h007B, 6};
    exp_img = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000};

    // Reset state
    #12;
    check("rst_count", pixel_count, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_img0", image_out[0], 0);
    @(negedge clk);
    rstN = 1'b1;
    send_beat(1'b0, '0, 1'b0);
    check("rst_ready", pixel_ready, 1);

    // Frame 1: value = index, valid held high
    early = 0;
    for (int i = 0; i < NP; i++) begin
      send_beat(1'b1, nn_data_t'(i), i == 0);
      if (i < NP - 1 && start) early++;
    end
    check("f1_start_no_early", early, 0);
    check("f1_start_after_last", start, 1);
    check("f1_count_wrapped", pixel_count, 0);
    check("f1_fire_ready", pixel_ready, 0);
    bad = 0;
    for (int k = 0; k < NP; k++) if (image_out[k] != nn_data_t'(k)) bad++;
    check("f1_image_bad_entries", bad, 0);

    // WAIT with valid held high: nothing accepted
    rdy_seen = 0;
    for (int c = 0; c < 50; c++) begin
      send_beat(1'b1, 16'h7777, 1'b0);
      if (pixel_ready) rdy_seen++;
    end
    check("wait_ready_low", rdy_seen, 0);
    check("wait_busy", busy, 1);
    check("wait_count", pixel_count, 0);
    check("wait_img0", image_out[0], 0);
    check("wait_img_last", image_out[NP-1], NP - 1);
    check("f1_start_pulses", n_start, 1);

    nn_done = 1'b1;
    send_beat(1'b0, '0, 1'b0);
    nn_done = 1'b0;
    check("done_ready", pixel_ready, 1);
    check("done_busy", busy, 0);

    // Gapped extreme values from the vector table
    for (int v = 0; v < 10; v++) begin
      send_beat(vecs[v].valid, vecs[v].data, vecs[v].sof);
      check($sformatf("gap_count_%0d", v), pixel_count, vecs[v].exp_count);
    end
    for (int k = 0; k < 6; k++)
      check($sformatf("gap_img_%0d", k), image_out[k], exp_img[k]);

    // nn_done during LOAD at count 100 is ignored
    for (int i = 6; i < 100; i++) send_beat(1'b1, nn_data_t'(i), 1'b0);
    check("load_count100", pixel_count, 100);
    nn_done = 1'b1;
    send_beat(1'b1, 16'sd100, 1'b0);
    nn_done = 1'b0;
    check("load_done_count", pixel_count, 101);
    check("load_done_ready", pixel_ready, 1);
    check("load_done_busy", busy, 0);

    // Reset after 400 pixels
    for (int i = 101; i < 400; i++) send_beat(1'b1, nn_data_t'(i), 1'b0);
    check("pre_rst_count", pixel_count, 400);
    pixel_valid = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    check("mid_rst_count", pixel_count, 0);
    check("mid_rst_img0", image_out[0], 0);
    check("mid_rst_img399", image_out[399], 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start", start, 0);
    @(negedge clk);
    rstN = 1'b1;
    send_beat(1'b0, '0, 1'b0);
    check("post_rst_ready", pixel_ready, 1);

    // Frame 2: exactly one start; nn_done during FIRE ignored
    s0 = n_start;
    for (int i = 0; i < NP; i++) send_beat(1'b1, nn_data_t'(1000 + i), i == 0);
    check("f2_start", start, 1);
    nn_done = 1'b1;
    send_beat(1'b0, '0, 1'b0);
    nn_done = 1'b0;
    check("fire_done_busy", busy, 1);
    check("fire_done_ready", pixel_ready, 0);
    send_beat(1'b0, '0, 1'b0);
    check("fire_done_still_wait", busy, 1);
    nn_done = 1'b1;
    send_beat(1'b0, '0, 1'b0);
    nn_done = 1'b0;
    check("f2_release_ready", pixel_ready, 1);
    check("f2_start_pulses", n_start - s0, 1);
    check("f2_img0", image_out[0], 1000);
    check("f2_img_last", image_out[NP-1], 1000 + NP - 1);

`ifdef IMG_LOADER_SOF_EN
    send_beat(1'b1, 16'h0BAD, 1'b0);
    pixel_valid = 1'b0;
    check("sof_drop_err", sync_err, 1);
    check("sof_drop_count", pixel_count, 0);
    check("sof_drop_img0", image_out[0], 1000);
    send_beat(1'b1, 16'sd11, 1'b1);
    check("sof_first_err", sync_err, 0);
    check("sof_first_count", pixel_count, 1);
    check("sof_first_img0", image_out[0], 11);
    for (int i = 1; i < 200; i++) send_beat(1'b1, nn_data_t'(i), 1'b0);
    check("sof_count200", pixel_count, 200);
    send_beat(1'b1, 16'sd55, 1'b1);
    pixel_valid = 1'b0;
    check("sof_resync_err", sync_err, 1);
    check("sof_resync_count", pixel_count, 1);
    check("sof_resync_img0", image_out[0], 55);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/image_stream_loader.md
# image_stream_loader

Front-end loader for the quantized MNIST classifier. It accepts a serial stream of signed 16-bit pixels over a valid/ready handshake and assembles them into the 784-entry image buffer that the network core reads in parallel. When the image is complete it pulses the network's `start` input, then holds the buffer stable and refuses new pixels until the network's `valid_out` returns. It is the writer side of the network's `input_image`/`start`/`valid_out` interface.

## Interface
- `N_PIXELS`, default 784: pixels per image (28x28).
- `DATA_W`, default 16: signed pixel width.
- `clk`  input  1  single system clock, rising edge.
- `rstN`  input  1  asynchronous, active-low reset.
- `pixel_data`  input  DATA_W signed  stream pixel, raster order, index 0 first.
- `pixel_valid`  input  1  source has a pixel on `pixel_data`.
- `pixel_ready`  output  1  loader can accept a pixel this cycle.
- `pixel_sof`  input  1  start-of-frame marker (only when `IMG_LOADER_SOF_EN` is defined).
- `nn_done`  input  1  connect to network `valid_out`; one-cycle pulse.
- `image_out`  output  [0:N_PIXELS-1] x DATA_W signed  connect to network `input_image`.
- `start`  output  1  one-cycle pulse to network `start`.
- `busy`  output  1  image handed off, waiting for `nn_done`.
- `pixel_count`  output  $clog2(N_PIXELS+1)  pixels accepted in the current frame.
- `sync_err`  output  1  one-cycle framing error pulse (only when `IMG_LOADER_SOF_EN` is defined).

## Operation
- States:
  - LOAD: `pixel_ready`=1; each accepted beat writes `image_out[pixel_count]` and increments `pixel_count`.
  - FIRE: `start`=1 for exactly one cycle.
  - WAIT: `pixel_ready`=0, `busy`=1.
- A beat is accepted when `pixel_valid && pixel_ready`. `pixel_data` is ignored when no beat is accepted.
- Transitions:
  - LOAD -> FIRE when the accepted beat has `pixel_count == N_PIXELS-1`. The counter wraps to 0 on that same edge.
  - FIRE -> WAIT unconditionally.
  - WAIT -> LOAD on `nn_done`.
- `nn_done` is ignored in LOAD and FIRE.
- `image_out` is written only in LOAD. It is held bit-stable through FIRE and WAIT until the next frame overwrites it entry by entry.
- `pixel_ready` is a pure decode of the state. It has no combinational path from `pixel_valid`.
- No arithmetic is applied to pixels; they are stored verbatim.

## Timing
- Reset (asynchronous, `rstN`=0) forces:
  - state LOAD, `pixel_count`=0, every `image_out` entry 0;
  - `start`=0, `busy`=0, `sync_err`=0;
  - `pixel_ready`=1 one cycle after `rstN` deasserts, as a decode of LOAD.
- `start` is registered. It is high in the cycle after the last pixel is accepted, with the full image already visible on `image_out`.
- Minimum frame time is N_PIXELS cycles at full throughput plus 1 (FIRE) plus the network latency, with no bubbles inside LOAD.
- `nn_done` arriving in the same cycle the loader enters WAIT is honoured: the loader is back in LOAD next cycle.
- Reset asserted mid-frame or during WAIT discards the partial image and clears the buffer. No `start` is issued.
- The source may hold `pixel_valid` high during WAIT. No beat is accepted and no data is lost.

## Configuration
- `IMG_LOADER_SOF_EN` defined: the `pixel_sof` and `sync_err` ports exist.
  - Accepted beat with `pixel_sof`=1 and `pixel_count`!=0: it is written to index 0, `pixel_count` becomes 1, and `sync_err` pulses (resync).
  - Accepted beat with `pixel_sof`=0 and `pixel_count`==0: it is dropped (not written, counter unchanged), and `sync_err` pulses.
  - Beat with `pixel_sof`=1 at `pixel_count`==0: normal.
- `IMG_LOADER_SOF_EN` undefined: neither port exists. Framing is purely by count.

## Structure
- Shared package `nn_pkg`:
  - `NN_DATA_W`=16, `NN_N_PIXELS`=784;
  - typedef `nn_data_t` (signed [15:0]);
  - the loader state enum `img_ld_state_e` {LOAD, FIRE, WAIT}.
- One sub-module is natural: `pixel_index_counter`. It is a wrapping counter with increment, load-to-1 and clear inputs, and a terminal-count flag. The buffer write and the FSM stay in the top.

## Test plan
- Reset, then stream 784 pixels with value = index (0..783), valid held high -> `start` pulses once, in the cycle after the beat with index 783; `image_out[k]`==k for all k; `pixel_ready`=0 and `busy`=1 afterwards.
- Hold `pixel_valid`=1 for 50 cycles in WAIT, then pulse `nn_done` -> no writes during WAIT; `pixel_ready`=1 the cycle after `nn_done`; the next frame starts at index 0.
- Random `pixel_valid` gaps (about 30% idle) with values -1, +32767, -32768 in a pattern -> stored exactly; `pixel_count` increments only on accepted beats.
- Assert `rstN`=0 after 400 pixels -> all outputs at reset values; a subsequent full 784-beat frame produces exactly one `start`.
- `nn_done` pulses during LOAD (at count 100) and during FIRE -> ignored; the state sequence is unchanged.
- With `IMG_LOADER_SOF_EN`:
  - `pixel_sof`=1 at count 200 -> `sync_err` pulses; that pixel lands at index 0 and `pixel_count`=1.
  - First beat with `pixel_sof`=0 -> dropped, `sync_err` pulses, `pixel_count` stays 0.
